systolic_array: RTL and testbench
=================================

SYSTOLIC_ARRAY -- requirements
Module: systolic_array

Interface
REQ-001 SHALL have parameter BITS_AB, default 8: signed width of A and B operands.
REQ-002 SHALL have parameter BITS_C, default 16: signed width of each accumulator and of Cin/Cout.
REQ-003 SHALL have parameter DIM, default 8: array is DIM x DIM processing elements (PEs).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port en  input  1  advance operand pipelines and accumulate.
REQ-007 SHALL have port clr  input  1  synchronous clear of all array state.
REQ-008 SHALL have port WrEn  input  1  write Cin into accumulator row Crow.
REQ-009 SHALL have port Crow  input  $clog2(DIM)  accumulator row selected for write and read.
REQ-010 SHALL have port A  input  signed [BITS_AB-1:0] x DIM  pre-skewed A column; A[r] enters row r.
REQ-011 SHALL have port B  input  signed [BITS_AB-1:0] x DIM  pre-skewed B row from the B skew buffer; B[c] enters column c.
REQ-012 SHALL have port Cin  input  signed [BITS_C-1:0] x DIM  accumulator write data, one per column.
REQ-013 SHALL have port Cout  output  signed [BITS_C-1:0] x DIM  accumulators of row Crow.
REQ-014 SHALL have port done  output  1  full product complete.

Function
REQ-015 Each PE(r,c) SHALL hold registers a_q, b_q (BITS_AB) and acc (BITS_C).
REQ-016 PE(r,c) operand inputs: a_in = A[r] if c==0 else a_q of PE(r,c-1); b_in = B[c] if r==0 else b_q of PE(r-1,c).
REQ-017 On a rising edge with en=1, clr=0: a_q<=a_in, b_q<=b_in, acc<=acc+a_in*b_in for every PE.
REQ-018 Product SHALL be a signed 2*BITS_AB-bit multiply, sign-extended (or truncated) to BITS_C; sum SHALL wrap modulo 2^BITS_C, no saturation.
REQ-019 With en=0, clr=0, WrEn=0: all registers SHALL hold.
REQ-020 WrEn=1, clr=0: acc of PE(Crow,c) <= Cin[c] for all c, overriding accumulation on that row that cycle; other rows and a_q/b_q follow en normally.
REQ-021 clr=1: all a_q, b_q, acc, cycle counter SHALL be 0 next edge; clr has priority over WrEn and en.
REQ-022 Cout[c] SHALL equal acc of PE(Crow,c) combinationally (zero-cycle read latency).
REQ-023 Cycle counter SHALL increment on each edge with en=1, clr=0, saturating at 3*DIM-2.
REQ-024 done SHALL be 1 exactly when counter == 3*DIM-2 (22 for DIM=8); WrEn does not affect counter or done.
REQ-025 Given upstream skew (A[r] element k presented at enabled cycle k+r, B[c] element k at cycle k+c, zeros otherwise), acc(r,c) SHALL equal sum over k of A(r,k)*B(k,c) when done rises.
REQ-026 Crow values >= DIM SHALL be ignored for writes and drive Cout to 0.

Reset
REQ-027 rst_n=0 SHALL immediately clear all a_q, b_q, acc, counter; Cout=0 and done=0 while reset is held, regardless of clk.
REQ-028 Reset asserted mid-computation SHALL discard all partial sums; first enabled cycle after release counts as cycle 0.

Verification
REQ-029 Identity: A=I, B(k,c)=k*8+c, skewed, 22 en cycles -> done=1 at cycle 22, row r Cout equals B row r.
REQ-030 Wrap: all A=-128, all B=-128, DIM=8, BITS_C=16 -> each acc = 8*16384 mod 65536 = 0; A=-128,B=127 only k=0 -> acc = -16256.
REQ-031 Write/readback: WrEn=1, Crow=3, Cin[c]=c+100 with en=0 -> next cycle Cout=100..107 at Crow=3, other rows unchanged; WrEn+en same cycle on row 3 -> row 3 = Cin, not Cin+product.
REQ-032 Stall: deassert en for 5 cycles at cycle 10 -> done delayed to 27th clock, results identical to REQ-029.
REQ-033 Clear/reset priority: clr=1 with WrEn=1, en=1 -> all acc 0, counter 0; rst_n low at cycle 12 -> Cout=0, done=0 immediately, rerun gives correct product.
REQ-034 Counter saturation: en held 40 cycles -> done stays 1 from cycle 22 until clr or reset.

Source files
------------

// File: rtl/systolic_array_if.sv
// Operand, control and accumulator-readback bundle for the systolic array.
// The master drives operands and control; the slave returns the selected row and done.
interface systolic_array_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
);
  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                      en;
  logic                      clr;
  logic                      WrEn;
  logic [CW-1:0]             Crow;
  logic signed [BITS_AB-1:0] A    [DIM];
  logic signed [BITS_AB-1:0] B    [DIM];
  logic signed [BITS_C-1:0]  Cin  [DIM];
  logic signed [BITS_C-1:0]  Cout [DIM];
  logic                      done;

  modport master (
    output en, clr, WrEn, Crow, A, B, Cin,
    input  Cout, done
  );

  modport slave (
    input  en, clr, WrEn, Crow, A, B, Cin,
    output Cout, done
  );
endinterface

// File: rtl/systolic_array.sv
// Output-stationary DIM x DIM MAC array: operands shift right/down one PE per enabled cycle.
// Row readback is combinational; there is no backpressure, en simply freezes the whole array.
module systolic_array #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  systolic_array_if.slave bus
);
  localparam int CW      = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int PW      = 2 * BITS_AB;
  localparam int CNT_MAX = 3 * DIM - 2;
  localparam int NW      = $clog2(CNT_MAX + 1);

  logic signed [BITS_AB-1:0] r_a   [DIM][DIM];
  logic signed [BITS_AB-1:0] r_b   [DIM][DIM];
  logic signed [BITS_C-1:0]  r_acc [DIM][DIM];
  logic [NW-1:0]             r_cnt;

  logic signed [BITS_AB-1:0] w_a_in [DIM][DIM];
  logic signed [BITS_AB-1:0] w_b_in [DIM][DIM];
  logic signed [BITS_C-1:0]  w_sum  [DIM][DIM];
  logic [DIM-1:0]            w_row_sel;
  logic                      w_done;

  for (genvar r = 0; r < DIM; r++) begin : g_row
    // Out-of-range Crow matches no row, so it neither writes nor reads anything.
    assign w_row_sel[r] = (bus.Crow == CW'(r));

    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic signed [PW-1:0] w_prod;

      if (c == 0) begin : g_a_edge
        assign w_a_in[r][c] = bus.A[r];
      end else begin : g_a_chain
        assign w_a_in[r][c] = r_a[r][c-1];
      end

      if (r == 0) begin : g_b_edge
        assign w_b_in[r][c] = bus.B[c];
      end else begin : g_b_chain
        assign w_b_in[r][c] = r_b[r-1][c];
      end

      // Full-precision signed product resized to the accumulator; the add wraps.
      assign w_prod       = w_a_in[r][c] * w_b_in[r][c];
      assign w_sum[r][c]  = r_acc[r][c] + BITS_C'(w_prod);
    end
  end

  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      bus.Cout[c] = '0;
      for (int r = 0; r < DIM; r++) begin
        if (w_row_sel[r]) bus.Cout[c] = r_acc[r][c];
      end
    end
  end

  assign w_done   = (r_cnt == NW'(CNT_MAX));
  assign bus.done = w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          r_a[r][c]   <= '0;
          r_b[r][c]   <= '0;
          r_acc[r][c] <= '0;
        end
      end
      r_cnt <= '0;
    end else if (bus.clr) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          r_a[r][c]   <= '0;
          r_b[r][c]   <= '0;
          r_acc[r][c] <= '0;
        end
      end
      r_cnt <= '0;
    end else begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (bus.en) begin
            r_a[r][c]   <= w_a_in[r][c];
            r_b[r][c]   <= w_b_in[r][c];
            r_acc[r][c] <= w_sum[r][c];
          end
          // Later assignment wins: a row write replaces that cycle's accumulation.
          if (bus.WrEn && w_row_sel[r]) r_acc[r][c] <= bus.Cin[c];
        end
      end
      if (bus.en && !w_done) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_systolic_array.sv
// Directed bench: stimulus queues expected row readbacks, a negedge monitor pops and compares.
module tb_systolic_array;
  localparam int DIM = 8;
  localparam int BA  = 8;
  localparam int BC  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_if #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) sif ();

  systolic_array #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  typedef struct packed {
    logic [DIM*BC-1:0] cout;
    logic              done;
    logic              chk_cout;
    logic [2:0]        row;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  logic  chk_vld     = 1'b0;

  logic signed [BA-1:0] ma [DIM][DIM];
  logic signed [BA-1:0] mb [DIM][DIM];
  logic signed [BC-1:0] ex [DIM];

  // Monitor: compares whatever row the stimulus selected while chk_vld is up.
  always @(negedge clk) begin
    if (chk_vld) begin
      exp_t              e;
      string             nm;
      logic [DIM*BC-1:0] act;
      for (int c = 0; c < DIM; c++) act[c*BC +: BC] = sif.Cout[c];
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty: output sampled with no expectation, done=%0b cout=%h", sif.done, act);
      end else begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        if (sif.done !== e.done || (e.chk_cout && act !== e.cout)) begin
          miscompares++;
          $display("FAIL %s row%0d: got done=%0b cout=%h, want done=%0b cout=%h",
                   nm, e.row, sif.done, act, e.done, e.cout);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    sif.en   = 1'b0;
    sif.clr  = 1'b0;
    sif.WrEn = 1'b0;
    for (int c = 0; c < DIM; c++) begin
      sif.A[c]   = '0;
      sif.B[c]   = '0;
      sif.Cin[c] = '0;
    end
  endtask

  task automatic do_clr();
    drive_idle();
    sif.clr = 1'b1;
    step();
    sif.clr = 1'b0;
  endtask

  task automatic expect_vec(input string nm, input int row, input bit chk, input bit dn);
    exp_t e;
    e.cout = '0;
    for (int c = 0; c < DIM; c++) e.cout[c*BC +: BC] = ex[c];
    e.done     = dn;
    e.chk_cout = chk;
    e.row      = row[2:0];
    sif.en     = 1'b0;
    sif.WrEn   = 1'b0;
    sif.clr    = 1'b0;
    sif.Crow   = row[2:0];
    sb_q.push_back(e);
    nm_q.push_back(nm);
    chk_vld = 1'b1;
    step();
    chk_vld = 1'b0;
  endtask

  // Enabled cycles t0..t1-1 of a skewed product of ma x mb.
  task automatic run_cycles(input int t0, input int t1);
    for (int t = t0; t < t1; t++) begin
      for (int i = 0; i < DIM; i++) begin
        sif.A[i] = '0;
        sif.B[i] = '0;
        if (t - i >= 0 && t - i < DIM) begin
          sif.A[i] = ma[i][t-i];
          sif.B[i] = mb[t-i][i];
        end
      end
      sif.en   = 1'b1;
      sif.clr  = 1'b0;
      sif.WrEn = 1'b0;
      step();
    end
    drive_idle();
  endtask

  task automatic idle_garbage(input int n);
    drive_idle();
    for (int c = 0; c < DIM; c++) begin
      sif.A[c] = 8'sd85;
      sif.B[c] = -8'sd7;
    end
    for (int i = 0; i < n; i++) step();
    drive_idle();
  endtask

  task automatic set_identity();
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        ma[r][k] = (r == k) ? 8'sd1 : 8'sd0;
        mb[r][k] = BA'(r * 8 + k);
      end
  endtask

  task automatic ident_row(input int r);
    for (int c = 0; c < DIM; c++) ex[c] = BC'(r * 8 + c);
  endtask

  task automatic fill_ex(input int v);
    for (int c = 0; c < DIM; c++) ex[c] = BC'(v);
  endtask

  task automatic model_row(input int r);
    logic signed [BC-1:0] s;
    for (int c = 0; c < DIM; c++) begin
      s = '0;
      for (int k = 0; k < DIM; k++) s = s + BC'(ma[r][k] * mb[k][c]);
      ex[c] = s;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    sif.Crow = '0;
    rst_n    = 1'b0;
    step();
    fill_ex(0);
    expect_vec("reset_state", 0, 1, 0);
    rst_n = 1'b1;

    // Identity product and done timing
    set_identity();
    run_cycles(0, 21);
    fill_ex(0);
    expect_vec("ident_done_early", 0, 0, 0);
    run_cycles(21, 22);
    for (int r = 0; r < DIM; r++) begin
      ident_row(r);
      expect_vec("ident", r, 1, 1);
    end

    // Counter saturates; zero-padded tail leaves results intact
    run_cycles(22, 40);
    ident_row(5);
    expect_vec("saturate", 5, 1, 1);

    // clr beats WrEn and en
    sif.clr  = 1'b1;
    sif.en   = 1'b1;
    sif.WrEn = 1'b1;
    sif.Crow = 3'd3;
    for (int c = 0; c < DIM; c++) begin
      sif.Cin[c] = 16'sd77;
      sif.A[c]   = 8'sd9;
      sif.B[c]   = 8'sd9;
    end
    step();
    drive_idle();
    fill_ex(0);
    expect_vec("clr_prio_row3", 3, 1, 0);
    expect_vec("clr_prio_row0", 0, 1, 0);

    // Wrap: 8 * (-128*-128) = 131072 == 0 mod 2^16
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        ma[r][k] = -8'sd128;
        mb[r][k] = -8'sd128;
      end
    run_cycles(0, 22);
    fill_ex(0);
    expect_vec("wrap_zero", 4, 1, 1);

    do_clr();
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++)
        mb[r][k] = (r == 0) ? 8'sd127 : 8'sd0;
    run_cycles(0, 22);
    fill_ex(-16256);
    expect_vec("wrap_neg", 0, 1, 1);
    expect_vec("wrap_neg", 7, 1, 1);

    // Row write with en=0, then readback; done unaffected
    sif.WrEn = 1'b1;
    sif.Crow = 3'd3;
    for (int c = 0; c < DIM; c++) sif.Cin[c] = BC'(c + 100);
    step();
    drive_idle();
    for (int c = 0; c < DIM; c++) ex[c] = BC'(c + 100);
    expect_vec("wr_row3", 3, 1, 1);
    fill_ex(-16256);
    expect_vec("wr_row2_hold", 2, 1, 1);

    // Row write overrides a same-cycle accumulation
    do_clr();
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < DIM; c++) begin
        sif.A[c]   = 8'sd2;
        sif.B[c]   = 8'sd3;
        sif.Cin[c] = BC'(c + 100);
      end
      sif.en   = 1'b1;
      sif.WrEn = (t == 3);
      sif.Crow = 3'd3;
      step();
    end
    drive_idle();
    for (int c = 0; c < DIM; c++) ex[c] = BC'(c + 100);
    expect_vec("wr_en_row3", 3, 1, 0);
    ex[0] = 16'sd12; ex[1] = 16'sd12; ex[2] = 16'sd12; ex[3] = 16'sd6;
    ex[4] = 16'sd0;  ex[5] = 16'sd0;  ex[6] = 16'sd0;  ex[7] = 16'sd0;
    expect_vec("wr_en_row2", 2, 1, 0);

    // Stall of 5 cycles at cycle 10
    do_clr();
    set_identity();
    run_cycles(0, 10);
    idle_garbage(5);
    run_cycles(10, 21);
    fill_ex(0);
    expect_vec("stall_done_early", 0, 0, 0);
    run_cycles(21, 22);
    ident_row(0);
    expect_vec("stall", 0, 1, 1);
    ident_row(7);
    expect_vec("stall", 7, 1, 1);

    // Async reset mid-run, then a fresh general product
    do_clr();
    set_identity();
    run_cycles(0, 12);
    sif.Crow = 3'd1;
    #2;
    rst_n = 1'b0;
    fill_ex(0);
    expect_vec("rst_mid", 1, 1, 0);
    rst_n = 1'b1;
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) begin
        ma[r][k] = BA'(((r + k) % 3) - 1);
        mb[r][k] = BA'(r - k);
      end
    run_cycles(0, 22);
    for (int r = 0; r < DIM; r += 3) begin
      model_row(r);
      expect_vec("rerun", r, 1, 1);
    end

    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
